// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, error codes and parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_tx_state_t;

  localparam logic [1:0] PS2_ERR_NONE    = 2'd0;
  localparam logic [1:0] PS2_ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] PS2_ERR_NACK    = 2'd2;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Raw PS/2 line conditioning: 2-flop synchronizer, 4-sample agreement filter, falling-edge strobe.
module ps2_line_filter (
  input  logic clk_sys,
  input  logic reset,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic [2:0] hist_q;
  logic       level_q;
  logic       level_d;
  logic       fall_q;

  // The newest synchronized sample plus three older ones must all agree before the level moves.
  always_comb begin
    level_d = level_q;
    if (&{hist_q, sync_q[1]}) begin
      level_d = 1'b1;
    end else if (~|{hist_q, sync_q[1]}) begin
      level_d = 1'b0;
    end else begin
      level_d = level_q;
    end
  end

  // Synchronizer, sample history, filtered level and fall strobe registers; idle lines float high.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b11;
      hist_q  <= 3'b111;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], line_i};
      hist_q  <= {hist_q[1:0], sync_q[1]};
      level_q <= level_d;
      fall_q  <= level_q & ~level_d;
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain clock/data through pull-low enables.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_KHZ     = 28000,
  parameter int unsigned INHIBIT_US  = 120,
  parameter int unsigned START_TO_MS = 15,
  parameter int unsigned EDGE_TO_US  = 2000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_active,
  output logic       tx_done,
  output logic       tx_error,
  output logic [1:0] err_code,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  output logic       ps2_kbd_clk_oe,
  output logic       ps2_kbd_data_oe
);

  localparam int unsigned INHIBIT_CYC = INHIBIT_US * CLK_KHZ / 1000;
  localparam int unsigned START_CYC   = START_TO_MS * CLK_KHZ;
  localparam int unsigned EDGE_CYC    = EDGE_TO_US * CLK_KHZ / 1000;
  localparam logic [31:0] INHIBIT_LD  = 32'(INHIBIT_CYC - 1);
  localparam logic [31:0] START_LD    = 32'(START_CYC - 1);
  localparam logic [31:0] EDGE_LD     = 32'(EDGE_CYC - 1);
  localparam logic        INHIBIT_ONE = (INHIBIT_CYC <= 32'd1);

  ps2_tx_state_t state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [3:0]    bitn_q, bitn_d;
  logic [9:0]    frame_q, frame_d;
  logic          ack_q, ack_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          tx_done_q, tx_done_d;
  logic          tx_error_q, tx_error_d;
  logic          timeout_s;

  logic clk_level_s, clk_fall_s;
  logic data_level_s, data_fall_unused_s;

  ps2_line_filter u_clk_filter (
    .clk_sys (clk_sys),
    .reset   (reset),
    .line_i  (ps2_kbd_clk),
    .level_o (clk_level_s),
    .fall_o  (clk_fall_s)
  );

  ps2_line_filter u_data_filter (
    .clk_sys (clk_sys),
    .reset   (reset),
    .line_i  (ps2_kbd_data),
    .level_o (data_level_s),
    .fall_o  (data_fall_unused_s)
  );

  // Next-state logic; cnt_q is the inhibit timer in INHIBIT and the watchdog in every later state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitn_d     = bitn_q;
    frame_d    = frame_q;
    ack_d      = ack_q;
    err_code_d = err_code_q;
    clk_oe_d   = 1'b0;
    data_oe_d  = data_oe_q;
    tx_done_d  = 1'b0;
    tx_error_d = 1'b0;
    timeout_s  = 1'b0;
    case (state_q)
      IDLE: begin
        data_oe_d = 1'b0;
        if (tx_valid) begin
          state_d    = INHIBIT;
          frame_d    = {1'b1, odd_parity(tx_data), tx_data};
          bitn_d     = 4'd0;
          err_code_d = PS2_ERR_NONE;
          cnt_d      = INHIBIT_LD;
          clk_oe_d   = 1'b1;
          data_oe_d  = INHIBIT_ONE;
        end else begin
          state_d = IDLE;
        end
      end
      INHIBIT: begin
        clk_oe_d = 1'b1;
        if (cnt_q == 32'd0) begin
          state_d   = REQ;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          cnt_d     = START_LD;
        end else begin
          cnt_d     = cnt_q - 32'd1;
          data_oe_d = (cnt_q == 32'd1) ? 1'b1 : data_oe_q;
        end
      end
      REQ: begin
        if (clk_fall_s) begin
          data_oe_d = ~frame_q[0];
          bitn_d    = 4'd1;
          state_d   = SEND;
          cnt_d     = EDGE_LD;
        end else if (cnt_q == 32'd0) begin
          timeout_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      SEND: begin
        if (clk_fall_s) begin
          cnt_d = EDGE_LD;
          if (bitn_q == 4'd10) begin
            ack_d     = ~data_level_s;
            data_oe_d = 1'b0;
            state_d   = ACK;
          end else begin
            data_oe_d = ~frame_q[bitn_q];
            bitn_d    = bitn_q + 4'd1;
          end
        end else if (cnt_q == 32'd0) begin
          timeout_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      ACK: begin
        data_oe_d = 1'b0;
        state_d   = WAIT_IDLE;
        if (clk_fall_s) begin
          cnt_d = EDGE_LD;
        end else if (cnt_q == 32'd0) begin
          timeout_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      WAIT_IDLE: begin
        data_oe_d = 1'b0;
        // Line release takes precedence over a watchdog expiring in the same cycle.
        if (clk_level_s && data_level_s) begin
          state_d = IDLE;
          if (ack_q) begin
            tx_done_d = 1'b1;
          end else begin
            tx_error_d = 1'b1;
            err_code_d = PS2_ERR_NACK;
          end
        end else if (clk_fall_s) begin
          cnt_d = EDGE_LD;
        end else if (cnt_q == 32'd0) begin
          timeout_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        data_oe_d = 1'b0;
      end
    endcase
    if (timeout_s) begin
      state_d    = IDLE;
      clk_oe_d   = 1'b0;
      data_oe_d  = 1'b0;
      tx_error_d = 1'b1;
      err_code_d = PS2_ERR_TIMEOUT;
    end else begin
      tx_error_d = tx_error_d;
    end
  end

  // State, frame and output registers; reset releases both lines without any pulse.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 32'd0;
      bitn_q     <= 4'd0;
      frame_q    <= 10'd0;
      ack_q      <= 1'b0;
      err_code_q <= PS2_ERR_NONE;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitn_q     <= bitn_d;
      frame_q    <= frame_d;
      ack_q      <= ack_d;
      err_code_q <= err_code_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      tx_done_q  <= tx_done_d;
      tx_error_q <= tx_error_d;
    end
  end

  assign tx_ready        = (state_q == IDLE);
  assign tx_active       = (state_q != IDLE);
  assign tx_done         = tx_done_q;
  assign tx_error        = tx_error_q;
  assign err_code        = err_code_q;
  assign ps2_kbd_clk_oe  = clk_oe_q;
  assign ps2_kbd_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a device model clocks frames and compares the wire against a frame model.
module tb_ps2_host_tx;

  localparam int N_INH   = 120;    // 120 us at 1 MHz
  localparam int N_START = 15000;  // 15 ms at 1 MHz

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_active, tx_done, tx_error;
  logic [1:0] err_code;
  logic       clk_oe, data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       clk_line, data_line;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int bad_active = 0;

  assign clk_line  = ~(clk_oe | dev_clk_low);
  assign data_line = ~(data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_KHZ     (1000),
    .INHIBIT_US  (120),
    .START_TO_MS (15),
    .EDGE_TO_US  (2000)
  ) dut (
    .clk_sys         (clk_sys),
    .reset           (reset),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .tx_active       (tx_active),
    .tx_done         (tx_done),
    .tx_error        (tx_error),
    .err_code        (err_code),
    .ps2_kbd_clk     (clk_line),
    .ps2_kbd_data    (data_line),
    .ps2_kbd_clk_oe  (clk_oe),
    .ps2_kbd_data_oe (data_oe)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_error) err_cnt <= err_cnt + 1;
    if ((tx_done || tx_error) && tx_active) bad_active <= bad_active + 1;
  end

  initial begin
    #(900_000);
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Wire image of a frame as the device reads it: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_model(input logic [7:0] d);
    int ones;
    ones = $countones(d);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
  endfunction

  task automatic send_and_inhibit(input logic [7:0] d);
    int hi;
    int drise;
    @(posedge clk_sys); #1;
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk_sys); #1;
    tx_valid = 1'b0;
    tx_data  = ~d;
    chk("accept", 32'({tx_ready, tx_active, clk_oe, err_code}), 32'(5'b01100));
    hi = 0;
    drise = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk_sys);
      if (!clk_oe) break;
      hi++;
      if (data_oe && drise == 0) drise = hi;
      if (k == 10) tx_valid = 1'b1;
      if (k == 12) tx_valid = 1'b0;
    end
    chk("inhibit_len", 32'(hi), 32'(N_INH));
    chk("data_oe_rise", 32'(drise), 32'(N_INH));
    chk("req_data_oe", 32'(data_oe), 32'd1);
  endtask

  task automatic dev_frame(input int half, input bit ack, input int nfalls, output logic [10:0] seen);
    seen = '0;
    for (int i = 0; i < nfalls; i++) begin
      repeat (half) @(posedge clk_sys);
      #1;
      seen[i] = data_line;
      if (i == 10 && ack) begin
        dev_data_low = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
      end
      dev_clk_low = 1'b1;
      if (i == nfalls - 1 && nfalls < 11) break;
      repeat (half) @(posedge clk_sys);
      #1;
      dev_clk_low = 1'b0;
    end
    if (nfalls == 11) begin
      repeat (half) @(posedge clk_sys);
      #1;
      dev_data_low = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input int half, input bit ack);
    logic [10:0] seen;
    int d0;
    int e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send_and_inhibit(d);
    dev_frame(half, ack, 11, seen);
    for (int k = 0; k < 100 && done_cnt == d0 && err_cnt == e0; k++) @(negedge clk_sys);
    repeat (10) @(negedge clk_sys);
    chk("frame_bits", 32'(seen), 32'(frame_model(d)));
    chk("done_pulses", 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
    chk("error_pulses", 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
    chk("err_code_after", 32'(err_code), ack ? 32'd0 : 32'd2);
    chk("back_idle", 32'({tx_ready, tx_active, clk_oe, data_oe}), 32'(4'b1000));
  endtask

  initial begin
    logic [10:0] seen;
    int n;
    int d0;
    int e0;

    repeat (3) @(posedge clk_sys);
    #1;
    chk("reset_state_in", 32'({tx_ready, tx_active, tx_done, tx_error, err_code, clk_oe, data_oe}), 32'(8'b1000_0000));
    reset = 1'b0;
    repeat (4) @(posedge clk_sys);
    #1;
    chk("reset_state", 32'({tx_ready, tx_active, tx_done, tx_error, err_code, clk_oe, data_oe}), 32'(8'b1000_0000));

    run_frame(8'hED, 20, 1'b1);
    run_frame(8'h01, 16, 1'b1);
    run_frame(8'hFF, 24, 1'b1);
    run_frame(8'h5A, 20, 1'b0);
    for (int r = 0; r < 4; r++) begin
      run_frame(8'($urandom_range(0, 255)), $urandom_range(12, 30), 1'($urandom_range(0, 1)));
    end

    // Device never answers the request-to-send.
    send_and_inhibit(8'hF4);
    n = 0;
    for (int k = 0; k < N_START + 100; k++) begin
      @(negedge clk_sys);
      n++;
      if (tx_error) break;
    end
    chk("timeout_cycles", 32'(n), 32'(N_START));
    chk("timeout_code", 32'(err_code), 32'd1);
    chk("timeout_lines", 32'({clk_oe, data_oe, tx_ready, tx_active}), 32'(4'b0010));

    // Reset lands just after the 5th clock fall, while data bit 4 of 0xED (a 0) is on the wire.
    send_and_inhibit(8'hED);
    dev_frame(20, 1'b1, 5, seen);
    repeat (8) @(posedge clk_sys);
    #1;
    chk("pre_reset", 32'({tx_active, data_oe}), 32'(2'b11));
    d0 = done_cnt;
    e0 = err_cnt;
    reset = 1'b1;
    #1;
    chk("reset_midframe", 32'({clk_oe, data_oe, tx_ready, tx_active}), 32'(4'b0010));
    repeat (3) @(posedge clk_sys);
    #1;
    dev_clk_low = 1'b0;
    reset = 1'b0;
    repeat (20) @(negedge clk_sys);
    chk("reset_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    run_frame(8'hF4, 20, 1'b1);

    chk("active_at_pulse", 32'(bad_active), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
